// File: rtl/cabac_sig_ctx_pkg.sv
// Shared constants for sig_coeff_flag context derivation: 4x4 scan orders,
// the 4x4-TU ctxIdxMap and the per-size context offsets.
package cabac_sig_ctx_pkg;

    typedef enum logic [1:0] {
        SCAN_DIAG = 2'd0,
        SCAN_HOR  = 2'd1,
        SCAN_VER  = 2'd2
    } scan_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Nibble i of each table is {yc[1:0], xc[1:0]} for in-CG scan position i.
    localparam logic [63:0] DIAG_SCAN_TAB = 64'hFBE7_AD36_9C25_8140;
    localparam logic [63:0] HOR_SCAN_TAB  = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] VER_SCAN_TAB  = 64'hFB73_EA62_D951_C840;

    // Nibble i is the context for raster index (y*4 + x) of a 4x4 TU.
    localparam logic [63:0] CTX_IDX_MAP   = 64'h8877_8866_5432_5410;

    localparam logic [5:0] OFFSET_8X8_DIAG     = 6'd9;
    localparam logic [5:0] OFFSET_8X8_OTHER    = 6'd15;
    localparam logic [5:0] OFFSET_LUMA_LARGE   = 6'd21;
    localparam logic [5:0] OFFSET_CHROMA_LARGE = 6'd12;
    localparam logic [5:0] CHROMA_CTX_BASE     = 6'd27;

    function automatic logic [3:0] scan_pos_xy(input logic [1:0] scan_idx,
                                               input logic [3:0] pos);
        case (scan_idx)
            SCAN_HOR: return HOR_SCAN_TAB[{pos, 2'b00} +: 4];
            SCAN_VER: return VER_SCAN_TAB[{pos, 2'b00} +: 4];
            default:  return DIAG_SCAN_TAB[{pos, 2'b00} +: 4];
        endcase
    endfunction

    function automatic logic [3:0] ctx_idx_map(input logic [3:0] idx);
        return CTX_IDX_MAP[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/cabac_sig_ctx_lane.sv
// One lane of sig_coeff_flag context derivation: in-CG scan position plus
// CG location, neighbour pattern and TU parameters -> context-RAM address.
module cabac_sig_ctx_lane
    import cabac_sig_ctx_pkg::*;
#(
    parameter int                ADDR_W    = 9,
    parameter logic [ADDR_W-1:0] ADDR_BASE = 9'h02c
) (
    input  logic [3:0]        pos_i,
    input  logic [2:0]        cg_x_i,
    input  logic [2:0]        cg_y_i,
    input  logic [1:0]        pattern_i,
    input  logic [2:0]        log2_size_i,
    input  logic [1:0]        scan_idx_i,
    input  logic              luma_i,
    output logic [ADDR_W-1:0] ctx_addr_o
);

    logic [3:0] xy;
    logic [1:0] xc, yc;
    logic [2:0] sum;
    logic [1:0] cnt;
    logic [5:0] offset;
    logic [5:0] ctx;
    logic       cg_origin;

    // NOTE: every variable gets a default at the top of the block, so no
    // path through the case/if tree can leave one unassigned and infer a latch.
    always_comb begin
        xy        = scan_pos_xy(scan_idx_i, pos_i);
        xc        = xy[1:0];
        yc        = xy[3:2];
        sum       = {1'b0, xc} + {1'b0, yc};
        cnt       = 2'd0;
        offset    = 6'd0;
        ctx       = 6'd0;
        cg_origin = (cg_x_i == 3'd0) && (cg_y_i == 3'd0);

        case (pattern_i)
            2'd0:    cnt = (sum == 3'd0) ? 2'd2 : (sum < 3'd3) ? 2'd1 : 2'd0;
            2'd1:    cnt = (yc == 2'd0) ? 2'd2 : (yc == 2'd1) ? 2'd1 : 2'd0;
            2'd2:    cnt = (xc == 2'd0) ? 2'd2 : (xc == 2'd1) ? 2'd1 : 2'd0;
            default: cnt = 2'd2;
        endcase

        if (log2_size_i == 3'd3) begin
            offset = (scan_idx_i == SCAN_DIAG) ? OFFSET_8X8_DIAG : OFFSET_8X8_OTHER;
        end else begin
            offset = luma_i ? OFFSET_LUMA_LARGE : OFFSET_CHROMA_LARGE;
        end

        if (log2_size_i == 3'd2) begin
            ctx = {2'b00, ctx_idx_map(xy)};
        end else if (cg_origin && (xy == 4'd0)) begin
            ctx = 6'd0;
        end else begin
            ctx = {4'd0, cnt} + ((luma_i && !cg_origin) ? 6'd3 : 6'd0) + offset;
        end

        if (!luma_i) begin
            ctx = ctx + CHROMA_CTX_BASE;
        end

        ctx_addr_o = ADDR_BASE + ADDR_W'(ctx);
    end

endmodule

// File: rtl/cabac_se_sig_coeff_ctx_gen.sv
// Walks each coded 4x4 CG in reverse scan order and emits LANES registered
// sig_coeff_flag context addresses per beat, tracking the TU's CSBF map.
module cabac_se_sig_coeff_ctx_gen
    import cabac_sig_ctx_pkg::*;
#(
    parameter int                LANES     = 2,
    parameter int                ADDR_W    = 9,
    parameter logic [ADDR_W-1:0] ADDR_BASE = 9'h02c
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tu_start_i,
    input  logic [2:0]              log2_size_i,
    input  logic [1:0]              scan_idx_i,
    input  logic [1:0]              coeff_type_i,
    input  logic                    cg_valid_i,
    output logic                    cg_ready_o,
    input  logic [2:0]              cg_x_i,
    input  logic [2:0]              cg_y_i,
    input  logic                    cg_coded_i,
    input  logic [3:0]              cg_first_pos_i,
    output logic                    ctx_valid_o,
    input  logic                    ctx_ready_i,
    output logic [LANES*ADDR_W-1:0] ctx_addr_o,
    output logic [LANES-1:0]        ctx_lane_en_o,
    output logic [LANES*4-1:0]      ctx_pos_o,
    output logic                    ctx_cg_done_o
);

    state_e                  state_q;
    logic [7:0][7:0]         csbf_q;
    logic [2:0]              log2_q;
    logic [1:0]              scan_q;
    logic                    luma_q;
    logic [2:0]              cg_x_q, cg_y_q;
    logic [1:0]              pattern_q;
    logic [5:0]              cur_q;
    logic                    ctx_valid_q;
    logic                    done_q;
    logic [LANES*ADDR_W-1:0] addr_q;
    logic [LANES-1:0]        en_q;
    logic [LANES*4-1:0]      pos_q;

    logic       cg_accept, load_new, beat_accept, advance;
    logic [3:0] cg_limit, x_p1, y_p1;
    logic [1:0] new_pattern;
    logic [5:0] src_cur;
    logic [2:0] src_x, src_y;
    logic [1:0] src_pattern;
    logic       done_d;
    logic [3:0]        lane_pos  [LANES];
    logic [LANES-1:0]  lane_en;
    logic [ADDR_W-1:0] lane_addr [LANES];
    logic              unused_ctype;

    assign unused_ctype = coeff_type_i[0];

    assign cg_ready_o  = !tu_start_i &&
                         ((state_q == ST_IDLE) || (state_q == ST_RUN && done_q && ctx_ready_i));
    assign cg_accept   = cg_valid_i && cg_ready_o;
    assign load_new    = cg_accept && cg_coded_i;
    assign beat_accept = ctx_valid_q && ctx_ready_i;
    assign advance     = beat_accept && !done_q;

    // Neighbours outside the TU's CG grid read as uncoded.
    assign cg_limit    = 4'd1 << (log2_q - 3'd2);
    assign x_p1        = {1'b0, cg_x_i} + 4'd1;
    assign y_p1        = {1'b0, cg_y_i} + 4'd1;
    assign new_pattern = {(y_p1 < cg_limit) ? csbf_q[cg_x_i][y_p1[2:0]] : 1'b0,
                          (x_p1 < cg_limit) ? csbf_q[x_p1[2:0]][cg_y_i] : 1'b0};

    assign src_cur     = load_new ? {2'b00, cg_first_pos_i} : cur_q - 6'(LANES);
    assign src_x       = load_new ? cg_x_i : cg_x_q;
    assign src_y       = load_new ? cg_y_i : cg_y_q;
    assign src_pattern = load_new ? new_pattern : pattern_q;
    assign done_d      = src_cur < 6'(LANES);

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_pos[k] = 4'(src_cur - 6'(k));
            lane_en[k]  = src_cur >= 6'(k);
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        cabac_sig_ctx_lane #(
            .ADDR_W    (ADDR_W),
            .ADDR_BASE (ADDR_BASE)
        ) u_lane (
            .pos_i       (lane_pos[g]),
            .cg_x_i      (src_x),
            .cg_y_i      (src_y),
            .pattern_i   (src_pattern),
            .log2_size_i (log2_q),
            .scan_idx_i  (scan_q),
            .luma_i      (luma_q),
            .ctx_addr_o  (lane_addr[g])
        );
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            // NOTE: the CSBF map is 64 flops, not a RAM, so it is cheap to
            // reset and tu_start_i must clear it in a single cycle anyway.
            csbf_q      <= '0;
            log2_q      <= '0;
            scan_q      <= '0;
            luma_q      <= 1'b0;
            cg_x_q      <= '0;
            cg_y_q      <= '0;
            pattern_q   <= '0;
            cur_q       <= '0;
            ctx_valid_q <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            en_q        <= '0;
            pos_q       <= '0;
        end else if (tu_start_i) begin
            state_q     <= ST_IDLE;
            csbf_q      <= '0;
            log2_q      <= log2_size_i;
            scan_q      <= scan_idx_i;
            luma_q      <= coeff_type_i[1];
            ctx_valid_q <= 1'b0;
            done_q      <= 1'b0;
            en_q        <= '0;
        end else begin
            if (cg_accept) begin
                csbf_q[cg_x_i][cg_y_i] <= cg_coded_i;
            end
            if (load_new || advance) begin
                state_q     <= ST_RUN;
                ctx_valid_q <= 1'b1;
                cur_q       <= src_cur;
                cg_x_q      <= src_x;
                cg_y_q      <= src_y;
                pattern_q   <= src_pattern;
                done_q      <= done_d;
                en_q        <= lane_en;
                for (int k = 0; k < LANES; k++) begin
                    addr_q[k*ADDR_W +: ADDR_W] <= lane_en[k] ? lane_addr[k] : '0;
                    pos_q[k*4 +: 4]            <= lane_en[k] ? lane_pos[k] : 4'd0;
                end
            end else if (beat_accept) begin
                state_q     <= ST_IDLE;
                ctx_valid_q <= 1'b0;
            end
        end
    end

    assign ctx_valid_o   = ctx_valid_q;
    assign ctx_addr_o    = addr_q;
    assign ctx_lane_en_o = en_q;
    assign ctx_pos_o     = pos_q;
    assign ctx_cg_done_o = done_q;

endmodule

// File: tb/tb_cabac_se_sig_coeff_ctx_gen.sv
// Directed bench for cabac_se_sig_coeff_ctx_gen: a behavioural context model
// fills a beat scoreboard that a monitor drains as beats are accepted.
module tb_cabac_se_sig_coeff_ctx_gen;

    localparam int LANES = 2;
    localparam int AW    = 9;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 tu_start_i;
    logic [2:0]           log2_size_i;
    logic [1:0]           scan_idx_i;
    logic [1:0]           coeff_type_i;
    logic                 cg_valid_i;
    logic                 cg_ready_o;
    logic [2:0]           cg_x_i;
    logic [2:0]           cg_y_i;
    logic                 cg_coded_i;
    logic [3:0]           cg_first_pos_i;
    logic                 ctx_valid_o;
    logic                 ctx_ready_i;
    logic [LANES*AW-1:0]  ctx_addr_o;
    logic [LANES-1:0]     ctx_lane_en_o;
    logic [LANES*4-1:0]   ctx_pos_o;
    logic                 ctx_cg_done_o;

    cabac_se_sig_coeff_ctx_gen #(
        .LANES     (LANES),
        .ADDR_W    (AW),
        .ADDR_BASE (9'h02c)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .tu_start_i     (tu_start_i),
        .log2_size_i    (log2_size_i),
        .scan_idx_i     (scan_idx_i),
        .coeff_type_i   (coeff_type_i),
        .cg_valid_i     (cg_valid_i),
        .cg_ready_o     (cg_ready_o),
        .cg_x_i         (cg_x_i),
        .cg_y_i         (cg_y_i),
        .cg_coded_i     (cg_coded_i),
        .cg_first_pos_i (cg_first_pos_i),
        .ctx_valid_o    (ctx_valid_o),
        .ctx_ready_i    (ctx_ready_i),
        .ctx_addr_o     (ctx_addr_o),
        .ctx_lane_en_o  (ctx_lane_en_o),
        .ctx_pos_o      (ctx_pos_o),
        .ctx_cg_done_o  (ctx_cg_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LANES*AW-1:0] addr;
        logic [LANES-1:0]    en;
        logic [LANES*4-1:0]  pos;
        logic                done;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    nbeats = 0;
    int    m_log2 = 0;
    int    m_scan = 0;
    bit    m_luma = 1'b0;
    bit    m_csbf [8][8];
    int    cmap [16] = '{0, 1, 4, 5, 2, 3, 4, 5, 6, 6, 8, 8, 7, 7, 8, 8};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Diagonal order generated by walking up-right anti-diagonals.
    function automatic void scan_xy(input int scan, input int pos, output int xc, output int yc);
        int i;
        xc = 0;
        yc = 0;
        if (scan == 1) begin
            xc = pos % 4;
            yc = pos / 4;
        end else if (scan == 2) begin
            xc = pos / 4;
            yc = pos % 4;
        end else begin
            i = 0;
            for (int d = 0; d < 7; d++) begin
                for (int x = 0; x <= d; x++) begin
                    if (x < 4 && (d - x) < 4) begin
                        if (i == pos) begin
                            xc = x;
                            yc = d - x;
                        end
                        i++;
                    end
                end
            end
        end
    endfunction

    function automatic logic [AW-1:0] model_addr(input int cgx, input int cgy, input int pat, input int pos);
        int xc, yc, ctx, cnt, s;
        scan_xy(m_scan, pos, xc, yc);
        cnt = 0;
        if (m_log2 == 2) begin
            ctx = cmap[yc*4 + xc];
        end else if (cgx == 0 && cgy == 0 && xc == 0 && yc == 0) begin
            ctx = 0;
        end else begin
            s = xc + yc;
            if (pat == 0)      cnt = (s == 0) ? 2 : (s < 3) ? 1 : 0;
            else if (pat == 1) cnt = (yc == 0) ? 2 : (yc == 1) ? 1 : 0;
            else if (pat == 2) cnt = (xc == 0) ? 2 : (xc == 1) ? 1 : 0;
            else               cnt = 2;
            ctx = cnt;
            if (m_luma && (cgx != 0 || cgy != 0)) ctx += 3;
            if (m_log2 == 3) ctx += (m_scan == 0) ? 9 : 15;
            else             ctx += m_luma ? 21 : 12;
        end
        if (!m_luma) ctx += 27;
        return AW'(44 + ctx);
    endfunction

    task automatic push_cg(input int cgx, input int cgy, input int first);
        int    lim, pat, cur, p;
        beat_t b;
        lim = 1 << (m_log2 - 2);
        pat = 0;
        if (cgx + 1 < lim && m_csbf[cgx+1][cgy]) pat += 1;
        if (cgy + 1 < lim && m_csbf[cgx][cgy+1]) pat += 2;
        cur = first;
        for (int n = 0; n < 16; n++) begin
            for (int k = 0; k < LANES; k++) begin
                p = cur - k;
                b.en[k]              = (p >= 0);
                b.addr[k*AW +: AW]   = (p >= 0) ? model_addr(cgx, cgy, pat, p) : '0;
                b.pos[k*4 +: 4]      = (p >= 0) ? 4'(p) : 4'd0;
            end
            b.done = (cur - LANES + 1 <= 0);
            sb.push_back(b);
            if (b.done) break;
            cur -= LANES;
        end
    endtask

    // Called in the post-posedge phase; returns in the post-posedge phase.
    task automatic tu(input int l2, input int sc, input logic [1:0] ct);
        tu_start_i   = 1'b1;
        log2_size_i  = 3'(l2);
        scan_idx_i   = 2'(sc);
        coeff_type_i = ct;
        @(negedge clk);
        check("tu_start_blocks_cg_ready", 64'(cg_ready_o), 64'd0);
        @(posedge clk); #1;
        tu_start_i = 1'b0;
        m_log2 = l2;
        m_scan = sc;
        m_luma = ct[1];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                m_csbf[i][j] = 1'b0;
    endtask

    task automatic send_cg(input int x, input int y, input bit coded, input int first, input bit b2b);
        bit ok;
        ok = 1'b0;
        if (coded) push_cg(x, y, first);
        m_csbf[x][y]   = coded;
        cg_valid_i     = 1'b1;
        cg_x_i         = 3'(x);
        cg_y_i         = 3'(y);
        cg_coded_i     = coded;
        cg_first_pos_i = 4'(first);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (cg_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        check("cg_accepted", 64'(ok), 64'd1);
        if (ok && b2b) begin
            check("b2b_with_done_beat_valid", 64'(ctx_valid_o), 64'd1);
            check("b2b_with_done_beat_done", 64'(ctx_cg_done_o), 64'd1);
        end
        @(posedge clk); #1;
        cg_valid_i = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !ctx_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain", 64'(ok), 64'd1);
        @(posedge clk); #1;
    endtask

    // Monitor: every accepted beat is compared against the scoreboard head.
    always @(negedge clk) begin
        beat_t b;
        bit    have;
        if (!rst && ctx_valid_o && ctx_ready_i) begin
            nbeats++;
            have = (sb.size() != 0);
            check("beat_expected", 64'(have), 64'd1);
            if (have) begin
                b = sb.pop_front();
                check("lane_en", 64'(ctx_lane_en_o), 64'(b.en));
                check("cg_done", 64'(ctx_cg_done_o), 64'(b.done));
                for (int k = 0; k < LANES; k++) begin
                    if (b.en[k]) begin
                        check("lane_addr", 64'(ctx_addr_o[k*AW +: AW]), 64'(b.addr[k*AW +: AW]));
                        check("lane_pos", 64'(ctx_pos_o[k*4 +: 4]), 64'(b.pos[k*4 +: 4]));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int n0;
        rst            = 1'b1;
        tu_start_i     = 1'b0;
        log2_size_i    = '0;
        scan_idx_i     = '0;
        coeff_type_i   = '0;
        cg_valid_i     = 1'b0;
        cg_x_i         = '0;
        cg_y_i         = '0;
        cg_coded_i     = 1'b0;
        cg_first_pos_i = '0;
        ctx_ready_i    = 1'b1;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                m_csbf[i][j] = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_cg_ready", 64'(cg_ready_o), 64'd1);
        check("reset_ctx_valid", 64'(ctx_valid_o), 64'd0);
        check("reset_ctx_addr", 64'(ctx_addr_o), 64'd0);
        check("reset_lane_en", 64'(ctx_lane_en_o), 64'd0);
        check("reset_pos", 64'(ctx_pos_o), 64'd0);
        check("reset_done", 64'(ctx_cg_done_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 4x4 luma diag, full CG
        tu(2, 0, 2'b10);
        n0 = nbeats;
        send_cg(0, 0, 1'b1, 15, 1'b0);
        @(negedge clk);
        check("4x4_first_addr", 64'(ctx_addr_o), 64'({9'h034, 9'h034}));
        check("4x4_first_pos", 64'(ctx_pos_o), 64'({4'd14, 4'd15}));
        @(posedge clk); #1;
        drain();
        check("4x4_beat_count", 64'(nbeats - n0), 64'd8);

        // 4x4 chroma diag, single position
        tu(2, 0, 2'b00);
        send_cg(0, 0, 1'b1, 0, 1'b0);
        @(negedge clk);
        check("chroma_addr_lane0", 64'(ctx_addr_o[AW-1:0]), 64'(9'h047));
        check("chroma_lane_en", 64'(ctx_lane_en_o), 64'(2'b01));
        check("chroma_done", 64'(ctx_cg_done_o), 64'd1);
        @(posedge clk); #1;
        drain();

        // 8x8 luma diag CG(1,1), then a 5-cycle stall mid-CG
        tu(3, 0, 2'b10);
        send_cg(1, 1, 1'b1, 15, 1'b0);
        @(negedge clk);
        check("8x8_pos15_addr", 64'(ctx_addr_o[AW-1:0]), 64'(9'h038));
        @(posedge clk); #1;
        ctx_ready_i = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", 64'(ctx_valid_o), 64'd1);
            if (sb.size() != 0) begin
                check("stall_addr", 64'(ctx_addr_o), 64'(sb[0].addr));
                check("stall_pos", 64'(ctx_pos_o), 64'(sb[0].pos));
            end
        end
        @(posedge clk); #1;
        ctx_ready_i = 1'b1;
        drain();

        // 16x16 luma: uncoded CG, then two coded CGs back to back
        tu(4, 0, 2'b10);
        send_cg(3, 3, 1'b0, 15, 1'b0);
        @(negedge clk);
        check("uncoded_no_beat", 64'(ctx_valid_o), 64'd0);
        @(posedge clk); #1;
        send_cg(2, 3, 1'b1, 15, 1'b0);
        send_cg(1, 3, 1'b1, 9, 1'b1);
        @(negedge clk);
        check("16x16_pattern1_addr", 64'(ctx_addr_o), 64'({9'h045, 9'h046}));
        @(posedge clk); #1;
        drain();

        // Abort mid-CG with tu_start_i; map must come back empty
        tu(3, 0, 2'b10);
        send_cg(1, 1, 1'b1, 15, 1'b0);
        send_cg(0, 2, 1'b1, 15, 1'b1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        ctx_ready_i = 1'b0;
        tu(3, 0, 2'b10);
        sb.delete();
        @(negedge clk);
        check("abort_valid_dropped", 64'(ctx_valid_o), 64'd0);
        @(posedge clk); #1;
        ctx_ready_i = 1'b1;
        send_cg(0, 1, 1'b1, 15, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
